// File: rtl/adc_seq_ctrl.sv
// Sequencer for a serial sleep-gated ADC: resets it, opens a DATA_W-clock capture window,
// shifts dout MSB-first into a word and hands it out through a 1-entry valid/ready buffer.
module adc_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int RST_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              continuous,
    output logic              adc_slp,
    output logic              adc_rst,
    input  logic              adc_dout,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              overrun,
    input  logic              clr_ovr,
    output logic [1:0]        dbg_state
);

    // Output handshake: a word transfers on any clk edge where sample_valid & sample_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RST  = 2'd1,
        S_GAP  = 2'd2,
        S_CAP  = 2'd3
    } state_t;

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] CAP_LAST = CNT_W'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              slp_q, slp_d;
    logic              rst_q, rst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;
    logic              word_done;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        word_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) state_d = S_RST;
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                cnt_d   = '0;
                state_d = S_CAP;
            end
            S_CAP: begin
                // The ADC shifts on this same edge, so the pre-edge dout is the current bit.
                shreg_d = {shreg_q[DATA_W-2:0], adc_dout};
                if (cnt_q == CAP_LAST) begin
                    word_done = 1'b1;
                    cnt_d     = '0;
                    state_d   = continuous ? S_GAP : S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Sleep/reset are registered from the next state so they switch on the state edge.
        slp_d = (state_d != S_CAP);
        rst_d = (state_d == S_RST);
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (word_done && (!valid_q || sample_ready)) begin
            data_d  = shreg_d;
            valid_d = 1'b1;
        end else if (!word_done && valid_q && sample_ready) begin
            valid_d = 1'b0;
        end
        if (clr_ovr) begin
            ovr_d = 1'b0;
        end else if (word_done && valid_q && !sample_ready) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            slp_q   <= 1'b1;
            rst_q   <= 1'b1;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            slp_q   <= slp_d;
            rst_q   <= rst_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign adc_slp      = slp_q;
    assign adc_rst      = rst_q;
    assign sample_data  = data_q;
    assign sample_valid = valid_q;
    assign overrun      = ovr_q;
    assign busy         = (state_q != S_IDLE);
    assign dbg_state    = state_q;

endmodule
